serial_compare_sequencer: RTL and testbench
===========================================

// Module: serial_compare_sequencer
//
// PURPOSE
//   Accepts a pair of parallel unsigned WIDTH-bit operands over a valid/ready handshake.
//   Feeds them MSB-first, one bit per clock, through an internal serial compare datapath.
//   Returns a one-hot less/equal/greater result over a second valid/ready handshake.
//   Terminates early at the first differing bit.
//   Sits between parallel producers and the bit-serial comparator: it sequences shift, count and result capture.
//
// PARAMETERS
//   WIDTH  8  operand width in bits; legal range WIDTH >= 2
//
// PORTS
//   clk          input   1                     single clock; all state updates on posedge
//   rst          input   1                     synchronous, active-high reset
//   in_valid     input   1                     operand pair on a/b is valid
//   in_ready     output  1                     sequencer can accept an operand pair
//   a            input   WIDTH                 operand A, unsigned
//   b            input   WIDTH                 operand B, unsigned
//   out_valid    output  1                     result fields are valid
//   out_ready    input   1                     consumer accepts the result
//   a_less_b     output  1                     A < B
//   a_eq_b       output  1                     A == B
//   a_greater_b  output  1                     A > B
//   bits_used    output  $clog2(WIDTH+1)       number of bit-serial cycles consumed (1..WIDTH)
//   busy         output  1                     high while not IDLE
//
// BEHAVIOUR
//   FSM states: IDLE, SHIFT, DONE. All outputs except in_ready and busy are registered.
//   Reset values: state=IDLE; out_valid=0; a_less_b=0; a_eq_b=0; a_greater_b=0; bits_used=0.
//     in_ready=0 while rst=1, then equals (state==IDLE).
//   IDLE:
//     - in_ready=1.
//     - On in_valid&in_ready: load sa<=a, sb<=b; set prev_eq<=1, prev_lt<=0, cnt<=0; go to SHIFT.
//     - a/b are sampled only on that edge.
//   SHIFT (one bit per cycle): x=sa[WIDTH-1], y=sb[WIDTH-1].
//     - eq = prev_eq & (x==y); lt = prev_eq ? (~x & y) : prev_lt.
//     - sa,sb shift left by 1; cnt <= cnt+1.
//     - Terminate if (x!=y) or cnt==WIDTH-1.
//     - On terminate: register a_eq_b=eq, a_less_b=lt, a_greater_b=~eq&~lt, bits_used=cnt+1.
//       Set out_valid<=1 and go to DONE.
//     - Otherwise update prev_eq/prev_lt and stay in SHIFT.
//   DONE:
//     - out_valid=1; exactly one result bit is high.
//     - All result fields are held stable until out_valid&out_ready.
//     - On the handshake edge: out_valid<=0, result bits and bits_used <= 0, go to IDLE.
//   Latency: acceptance edge to out_valid high = bits_used cycles.
//     bits_used = 1 + index (from MSB) of the first differing bit, or WIDTH if A == B.
//   Throughput: no overlap. in_ready=0 in SHIFT and DONE.
//     Next accept is at earliest the cycle after the result handshake (IDLE lasts at least 1 cycle).
//   When out_valid=0, all result bits and bits_used are 0.
//   Reset mid-operation (SHIFT or DONE):
//     - Aborts immediately to IDLE; the pending result is discarded.
//     - No out_valid pulse; out_valid drops on that edge.
//   in_valid in SHIFT/DONE is ignored; the producer holds the pair until in_ready.
//   out_ready outside DONE has no effect.
//   Operands are compared unsigned; WIDTH is fixed at elaboration.
//
// TESTING (WIDTH=8)
//   1. a=8'h5A, b=8'h5A accepted
//      -> after 8 cycles out_valid=1, a_eq_b=1, bits_used=8.
//   2. a=8'h80, b=8'h7F
//      -> out_valid 1 cycle after accept, a_greater_b=1, bits_used=1.
//   3. a=8'h12, b=8'h13
//      -> a_less_b=1, bits_used=8.
//      a=8'h00, b=8'h20 -> a_less_b=1, bits_used=3.
//   4. Hold out_ready=0 for 5 cycles in DONE
//      -> out_valid and results stable, in_ready=0, busy=1.
//      Release -> IDLE next cycle, outputs return to 0.
//   5. Assert rst for 1 cycle mid-SHIFT
//      -> state IDLE, out_valid never rises.
//      A new pair then completes normally.
//   6. Back-to-back pairs with out_ready tied 1
//      -> accept, result and handshake per pair; no dropped or duplicated results.
//      Randomised pairs match a reference < / == / > model.

Source files
------------

// File: rtl/serial_compare_sequencer.sv
// Bit-serial magnitude compare sequencer: takes an operand pair over a
// valid/ready handshake, walks the bits MSB-first one per clock and stops at
// the first differing bit. The result goes out as one-hot less/equal/greater
// over a second valid/ready handshake.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an operand pair, in_ready high
// SHIFT | comparing one bit per cycle, MSB first
// DONE  | result held on the outputs until out_ready
module serial_compare_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             a,
   input  logic [WIDTH-1:0]             b,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         a_less_b,
   output logic                         a_eq_b,
   output logic                         a_greater_b,
   output logic [$clog2(WIDTH+1)-1:0]   bits_used,
   output logic                         busy
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [CW-1:0]    cnt;
   logic             prev_eq;
   logic             prev_lt;

   logic             x;
   logic             y;
   logic             eq_bit;
   logic             lt_bit;
   logic             last;

   // in_ready is held low through reset so nothing is accepted on a reset edge
   assign in_ready = ~rst & (state == ST_IDLE);
   assign busy     = (state != ST_IDLE);

   // Per-bit compare of the current MSBs and the stop condition
   always_comb begin
      x      = sa[WIDTH-1];
      y      = sb[WIDTH-1];
      eq_bit = prev_eq & (x == y);
      lt_bit = prev_eq ? (~x & y) : prev_lt;
      last   = (x != y) || (cnt == CW'(WIDTH - 1));
   end

   // Sequencer FSM, shift registers, bit counter and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         sa          <= '0;
         sb          <= '0;
         cnt         <= '0;
         prev_eq     <= 1'b1;
         prev_lt     <= 1'b0;
         out_valid   <= 1'b0;
         a_less_b    <= 1'b0;
         a_eq_b      <= 1'b0;
         a_greater_b <= 1'b0;
         bits_used   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  sa      <= a;
                  sb      <= b;
                  prev_eq <= 1'b1;
                  prev_lt <= 1'b0;
                  cnt     <= '0;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               sa  <= {sa[WIDTH-2:0], 1'b0};
               sb  <= {sb[WIDTH-2:0], 1'b0};
               cnt <= cnt + CW'(1);
               if (last) begin
                  a_eq_b      <= eq_bit;
                  a_less_b    <= lt_bit;
                  a_greater_b <= ~eq_bit & ~lt_bit;
                  bits_used   <= cnt + CW'(1);
                  out_valid   <= 1'b1;
                  state       <= ST_DONE;
               end else begin
                  prev_eq <= eq_bit;
                  prev_lt <= lt_bit;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid   <= 1'b0;
                  a_less_b    <= 1'b0;
                  a_eq_b      <= 1'b0;
                  a_greater_b <= 1'b0;
                  bits_used   <= '0;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_compare_sequencer.sv
// Self-checking bench for serial_compare_sequencer (WIDTH=8): directed cases,
// back-pressure, reset abort and a randomised back-to-back stream, with
// expected results held in a scoreboard queue.
module tb_serial_compare_sequencer;

   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);

   typedef struct packed {
      logic          lt;
      logic          eq;
      logic          gt;
      logic [CW-1:0] bits;
   } res_t;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          out_valid;
   logic          out_ready;
   logic          a_less_b;
   logic          a_eq_b;
   logic          a_greater_b;
   logic [CW-1:0] bits_used;
   logic          busy;

   int   n_tests;
   int   n_fail;
   res_t sb_q[$];

   serial_compare_sequencer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .a_less_b   (a_less_b),
      .a_eq_b     (a_eq_b),
      .a_greater_b(a_greater_b),
      .bits_used  (bits_used),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: unsigned compare plus MSB-first position of the first difference
   function automatic res_t model(input logic [W-1:0] aa, input logic [W-1:0] bb);
      res_t r;
      logic found;
      r.lt  = (aa < bb);
      r.eq  = (aa == bb);
      r.gt  = (aa > bb);
      r.bits = CW'(W);
      found = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (!found && (aa[i] != bb[i])) begin
            r.bits = CW'(W - i);
            found  = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic res_t observed();
      res_t r;
      r.lt   = a_less_b;
      r.eq   = a_eq_b;
      r.gt   = a_greater_b;
      r.bits = bits_used;
      return r;
   endfunction

   // Present a pair at a negedge, wait for in_ready, push the expectation,
   // let the accepting posedge pass and drop in_valid.
   task automatic drive_accept(input logic [W-1:0] aa, input logic [W-1:0] bb, output bit ok);
      int guard;
      @(negedge clk);
      a        = aa;
      b        = bb;
      in_valid = 1'b1;
      guard    = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      ok = in_ready;
      if (ok) sb_q.push_back(model(aa, bb));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Count posedges from the accept edge until out_valid; flags any nonzero
   // result field or wrong in_ready/busy seen while the compare is running.
   task automatic wait_result(output int lat, output bit ok, output bit quiet_ok);
      lat      = 0;
      quiet_ok = 1'b1;
      while (!out_valid && lat < 40) begin
         if (a_less_b || a_eq_b || a_greater_b || bits_used != '0 || in_ready || !busy)
            quiet_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      ok = out_valid;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b1;
      a         = 8'h11;
      b         = 8'h22;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (observed() !== res_t'(0) || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b res=%h want valid=0 res=0", out_valid, observed());
      end
      n_tests++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: got in_ready=%b busy=%b want 0 0", in_ready, busy);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b0;
      #1;
      n_tests++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_idle: got in_ready=%b busy=%b want 1 0", in_ready, busy);
      end
   endtask

   task automatic test_compare(input logic [W-1:0] aa, input logic [W-1:0] bb);
      bit   ok;
      bit   quiet_ok;
      int   lat;
      res_t exp;
      drive_accept(aa, bb, ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL accept_%h_%h: in_ready never rose within bound", aa, bb);
         return;
      end
      exp = sb_q.pop_front();
      wait_result(lat, ok, quiet_ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL result_timeout_%h_%h: out_valid never rose", aa, bb);
         return;
      end
      n_tests++;
      if (lat != int'(exp.bits)) begin
         n_fail++;
         $display("FAIL latency_%h_%h: got %0d cycles want %0d", aa, bb, lat, exp.bits);
      end
      n_tests++;
      if (observed() !== exp) begin
         n_fail++;
         $display("FAIL result_%h_%h: got lt/eq/gt=%b%b%b bits=%0d want %b%b%b bits=%0d",
                  aa, bb, a_less_b, a_eq_b, a_greater_b, bits_used, exp.lt, exp.eq, exp.gt, exp.bits);
      end
      n_tests++;
      if (!quiet_ok) begin
         n_fail++;
         $display("FAIL shift_quiet_%h_%h: result fields/in_ready/busy wrong during SHIFT", aa, bb);
      end
      release_result();
      n_tests++;
      if (out_valid !== 1'b0 || observed() !== res_t'(0) || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL post_handshake_%h_%h: got valid=%b res=%h in_ready=%b busy=%b want 0 0 1 0",
                  aa, bb, out_valid, observed(), in_ready, busy);
      end
   endtask

   task automatic test_backpressure();
      bit   ok;
      bit   quiet_ok;
      int   lat;
      res_t exp;
      bit   stable_ok;
      drive_accept(8'h12, 8'h13, ok);
      if (ok) exp = sb_q.pop_front();
      else    exp = model(8'h12, 8'h13);
      wait_result(lat, ok, quiet_ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL backpressure_timeout: out_valid never rose");
         return;
      end
      stable_ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         if (out_valid !== 1'b1 || observed() !== exp || in_ready !== 1'b0 || busy !== 1'b1)
            stable_ok = 1'b0;
      end
      in_valid = 1'b0;
      n_tests++;
      if (!stable_ok) begin
         n_fail++;
         $display("FAIL backpressure_hold: got valid=%b res=%h in_ready=%b busy=%b want 1 %h 0 1",
                  out_valid, observed(), in_ready, busy, exp);
      end
      release_result();
      n_tests++;
      if (out_valid !== 1'b0 || observed() !== res_t'(0) || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL backpressure_release: got valid=%b res=%h in_ready=%b want 0 0 1",
                  out_valid, observed(), in_ready);
      end
   endtask

   task automatic test_reset_mid_shift();
      bit ok;
      bit rose;
      drive_accept(8'hF0, 8'hF0, ok);
      sb_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_state: got valid=%b busy=%b in_ready=%b want 0 0 0", out_valid, busy, in_ready);
      end
      @(negedge clk);
      rst  = 1'b0;
      rose = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) rose = 1'b1;
      end
      n_tests++;
      if (rose || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_no_result: got out_valid_rose=%b in_ready=%b want 0 1", rose, in_ready);
      end
      test_compare(8'h00, 8'h20);
   endtask

   task automatic test_back_to_back();
      localparam int N = 40;
      int got;
      int sent;
      out_ready = 1'b1;
      got  = 0;
      sent = 0;
      fork
         begin : producer
            logic [W-1:0] pa;
            logic [W-1:0] pb;
            int           guard;
            for (int i = 0; i < N; i++) begin
               pa = W'($urandom);
               case (i % 4)
                  0:       pb = pa;
                  1:       pb = pa ^ W'(1);
                  default: pb = W'($urandom);
               endcase
               @(negedge clk);
               a        = pa;
               b        = pb;
               in_valid = 1'b1;
               guard    = 0;
               while (!in_ready && guard < 100) begin
                  @(negedge clk);
                  guard++;
               end
               if (in_ready) begin
                  sb_q.push_back(model(pa, pb));
                  sent++;
               end
            end
            @(negedge clk);
            in_valid = 1'b0;
         end
         begin : consumer
            int   guard;
            res_t exp;
            guard = 0;
            while (got < N && guard < 3000) begin
               @(negedge clk);
               guard++;
               if (out_valid) begin
                  n_tests++;
                  if (sb_q.size() == 0) begin
                     n_fail++;
                     $display("FAIL b2b_extra_result: got res=%h with empty scoreboard", observed());
                  end else begin
                     exp = sb_q.pop_front();
                     if (observed() !== exp) begin
                        n_fail++;
                        $display("FAIL b2b_result_%0d: got %h want %h", got, observed(), exp);
                     end
                  end
                  got++;
               end
            end
         end
      join
      repeat (12) @(negedge clk);
      out_ready = 1'b0;
      n_tests++;
      if (got != N || sent != N || sb_q.size() != 0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_count: got sent=%0d results=%0d left=%0d valid=%b want %0d %0d 0 0",
                  sent, got, sb_q.size(), out_valid, N, N);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_compare(8'h5A, 8'h5A);
      test_compare(8'h80, 8'h7F);
      test_compare(8'h12, 8'h13);
      test_compare(8'h00, 8'h20);
      test_compare(8'hFF, 8'h00);
      test_compare(8'h00, 8'h00);
      test_backpressure();
      test_reset_mid_shift();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
